viterbi_decoder_param: RTL and testbench



---
 rtl/viterbi_decoder_param_pkg.sv | 26 ++
 rtl/viterbi_decoder_param_acs.sv | 30 +++
 rtl/viterbi_decoder_param.sv | 132 +++++++++++++
 tb/tb_viterbi_decoder_param.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/viterbi_decoder_param_pkg.sv
// viterbi_pkg: items shared by the Viterbi decoder top and its ACS unit.
//   K_DEFAULT / M_DEFAULT : default constraint length / path-metric width
//   S                     : trellis state count for the default K
//   metric_t              : path metric of the default width
//   parity(vec)           : XOR reduction (one convolutional code bit)
//   hamming2(a, b)        : Hamming distance between two 2-bit symbols
package viterbi_pkg;

  localparam int unsigned K_DEFAULT = 3;
  localparam int unsigned M_DEFAULT = 6;
  localparam int unsigned S         = 1 << (K_DEFAULT - 1);

  typedef logic [M_DEFAULT-1:0] metric_t;

  function automatic logic parity(input logic [31:0] vec);
    return ^vec;
  endfunction

  // Result is 0..2: the high bit is set only when both code bits differ.
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_decoder_param_acs.sv
// viterbi_acs_unit: compare-select for one next state of the trellis.
// The caller supplies both candidate metrics already including their branch
// metric. On a tie predecessor p0 wins.
//   cand0_i / cand1_i : candidate path metrics via p0 / p1
//   hist0_i / hist1_i : stored survivor history (D-1 bits) of p0 / p1
//   u_i               : input bit implied by this next state
//   pm_o              : winning metric
//   surv_o            : new D-bit survivor {winner history, u}
module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int unsigned M = 6,
  parameter int unsigned D = 15
) (
  input  logic [M-1:0] cand0_i,
  input  logic [M-1:0] cand1_i,
  input  logic [D-2:0] hist0_i,
  input  logic [D-2:0] hist1_i,
  input  logic         u_i,
  output logic [M-1:0] pm_o,
  output logic [D-1:0] surv_o
);

  logic sel1;

  assign sel1   = cand1_i < cand0_i;
  assign pm_o   = sel1 ? cand1_i : cand0_i;
  assign surv_o = sel1 ? {hist1_i, u_i} : {hist0_i, u_i};

endmodule

// File: rtl/viterbi_decoder_param.sv
// viterbi_decoder_param: hard-decision Viterbi decoder for rate-1/2
// convolutional codes, register-exchange survivors, fixed latency D symbols.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   In_Valid   : Encoded_In carries a symbol this cycle
//   Encoded_In : received symbol {c0, c1}
//   Out_Valid  : one-cycle pulse per accepted symbol once D symbols were seen
//   Decode_Out : decoded bit, held between accepted symbols
// Build option VITERBI_METRIC_NORM_EN: when defined, the minimum new metric is
// subtracted from all metrics every accepted symbol; otherwise each
// add-compare saturates at 2^M-1.
module viterbi_decoder_param
  import viterbi_pkg::*;
#(
  parameter int unsigned K  = 3,
  parameter int unsigned G0 = 'b111,
  parameter int unsigned G1 = 'b101,
  parameter int unsigned D  = 15,
  parameter int unsigned M  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       In_Valid,
  input  logic [1:0] Encoded_In,
  output logic       Out_Valid,
  output logic       Decode_Out
);

  localparam int unsigned NS = 1 << (K - 1);
  localparam int unsigned SW = K - 1;
  localparam int unsigned CW = $clog2(D + 1);
  localparam logic [M-1:0] PM_INIT = {1'b1, {(M-1){1'b0}}};

  logic [M-1:0]  pm_q   [NS];
  logic [M-1:0]  pm_d   [NS];
  logic [M-1:0]  pm_acs [NS];
  // The oldest survivor bit is only ever consumed as the output, so storage
  // keeps D-1 bits and the full D-bit survivor exists only combinationally.
  logic [D-2:0]  hist_q [NS];
  logic [D-1:0]  surv_d [NS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] best;
  logic [M-1:0]  pm_min;

  for (genvar gs = 0; gs < NS; gs++) begin : g_state
    // Next state gs = {u, p[K-2:1]}; both predecessors share the upper bits.
    localparam int unsigned P0 = (2 * gs) % NS;
    localparam int unsigned P1 = P0 + 1;
    localparam bit          U  = ((gs >> (K - 2)) & 1) != 0;
    localparam int unsigned R0 = (int'(U) << (K - 1)) | P0;
    localparam int unsigned R1 = (int'(U) << (K - 1)) | P1;

    logic [1:0]   exp0, exp1, bm0, bm1;
    logic [M-1:0] cand0, cand1;

    assign exp0 = {parity(R0 & G0), parity(R0 & G1)};
    assign exp1 = {parity(R1 & G0), parity(R1 & G1)};
    assign bm0  = hamming2(Encoded_In, exp0);
    assign bm1  = hamming2(Encoded_In, exp1);

`ifdef VITERBI_METRIC_NORM_EN
    assign cand0 = pm_q[P0] + {{(M-2){1'b0}}, bm0};
    assign cand1 = pm_q[P1] + {{(M-2){1'b0}}, bm1};
`else
    logic [M:0] sum0, sum1;
    assign sum0  = {1'b0, pm_q[P0]} + {{(M-1){1'b0}}, bm0};
    assign sum1  = {1'b0, pm_q[P1]} + {{(M-1){1'b0}}, bm1};
    assign cand0 = sum0[M] ? '1 : sum0[M-1:0];
    assign cand1 = sum1[M] ? '1 : sum1[M-1:0];
`endif

    viterbi_acs_unit #(
      .M(M),
      .D(D)
    ) u_acs (
      .cand0_i(cand0),
      .cand1_i(cand1),
      .hist0_i(hist_q[P0]),
      .hist1_i(hist_q[P1]),
      .u_i    (U),
      .pm_o   (pm_acs[gs]),
      .surv_o (surv_d[gs])
    );
  end

  // Lowest new metric; strict compare keeps the lowest index on ties.
  always_comb begin
    best   = '0;
    pm_min = pm_acs[0];
    for (int unsigned s = 1; s < NS; s++) begin
      if (pm_acs[s] < pm_min) begin
        pm_min = pm_acs[s];
        best   = SW'(s);
      end
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
`ifdef VITERBI_METRIC_NORM_EN
      pm_d[s] = pm_acs[s] - pm_min;
`else
      pm_d[s] = pm_acs[s];
`endif
    end
  end

  assign cnt_d = (cnt_q == CW'(D)) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NS; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        hist_q[s] <= '0;
      end
      cnt_q      <= '0;
      Out_Valid  <= 1'b0;
      Decode_Out <= 1'b0;
    end else if (In_Valid) begin
      for (int unsigned s = 0; s < NS; s++) begin
        pm_q[s]   <= pm_d[s];
        hist_q[s] <= surv_d[s][D-2:0];
      end
      cnt_q      <= cnt_d;
      Out_Valid  <= (cnt_d == CW'(D));
      Decode_Out <= surv_d[best][D-1];
    end else begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_param.sv
module tb_viterbi_decoder_param;

  localparam int unsigned K  = 3;
  localparam int unsigned D  = 15;
  localparam int unsigned M  = 6;
  localparam int          DI = D;
  localparam int          NDATA = 30;
  // First bit sent is the MSB; begins with the 1,0,1,1,0,0 example stream.
  localparam logic [NDATA-1:0] DATA = 30'b101100_111001_010011_100010_110100;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       In_Valid   = 1'b0;
  logic [1:0] Encoded_In = 2'b00;
  logic       Out_Valid;
  logic       Decode_Out;

  always #5 clk = ~clk;

  viterbi_decoder_param #(
    .K (K),
    .G0('b111),
    .G1('b101),
    .D (D),
    .M (M)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .In_Valid  (In_Valid),
    .Encoded_In(Encoded_In),
    .Out_Valid (Out_Valid),
    .Decode_Out(Decode_Out)
  );

  int         checks = 0;
  int         errors = 0;
  int         n;
  logic       exp_dec;
  logic [1:0] enc_st;
  logic       hist[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference encoder: r = {u, state}, c0 = ^(r & 7), c1 = ^(r & 5).
  function automatic logic [1:0] enc(input logic u, input logic [1:0] st);
    logic [2:0] r;
    r = {u, st};
    return {^(r & 3'b111), ^(r & 3'b101)};
  endfunction

  // Reset with a valid symbol present: reset must win and discard it.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    In_Valid   = 1'b1;
    Encoded_In = 2'b11;
    @(posedge clk);
    #1;
    check_eq("rst_vld", 32'(Out_Valid), 32'd0);
    check_eq("rst_dec", 32'(Decode_Out), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    In_Valid = 1'b0;
    n        = 0;
    exp_dec  = 1'b0;
    enc_st   = 2'b00;
    hist.delete();
  endtask

  task automatic send_bit(input logic u, input logic [1:0] flip, input string tag);
    logic [1:0] sym;
    sym    = enc(u, enc_st) ^ flip;
    enc_st = {u, enc_st[1]};
    hist.push_back(u);
    @(negedge clk);
    In_Valid   = 1'b1;
    Encoded_In = sym;
    @(posedge clk);
    #1;
    if (n >= DI - 1) exp_dec = hist[n-DI+1];
    check_eq($sformatf("%s%0d_vld", tag, n), 32'(Out_Valid), (n >= DI - 1) ? 32'd1 : 32'd0);
    check_eq($sformatf("%s%0d_dec", tag, n), 32'(Decode_Out), 32'(exp_dec));
    n++;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    In_Valid   = 1'b0;
    Encoded_In = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    check_eq($sformatf("%s%0d_idle_vld", tag, n), 32'(Out_Valid), 32'd0);
    check_eq($sformatf("%s%0d_idle_dec", tag, n), 32'(Decode_Out), 32'(exp_dec));
  endtask

  // DATA followed by D-1 zero tail bits, optionally cut short at stop_at.
  task automatic send_data(input string tag, input int flip_at, input int gaps, input int stop_at);
    for (int i = 0; i < NDATA + DI - 1 && i < stop_at; i++) begin
      send_bit((i < NDATA) ? DATA[NDATA-1-i] : 1'b0, (i == flip_at) ? 2'b10 : 2'b00, tag);
      for (int g = 0; g < gaps; g++) idle_cycle(tag);
    end
    @(negedge clk);
    In_Valid = 1'b0;
  endtask

  initial begin
    int         since;
    logic       u;
    logic [1:0] flip;

    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'b0, 2'b00, "zero");

    do_reset();
    send_data("clean", -1, 0, 1000);

    do_reset();
    send_data("err", 5, 0, 1000);

    do_reset();
    send_data("gap", -1, 2, 1000);

    do_reset();
    send_data("pre", -1, 0, 20);
    do_reset();
    send_data("fresh", -1, 0, 1000);

    // Random data with isolated single-bit errors at least 20 symbols apart,
    // each within the code's correction power, so every bit must decode.
    do_reset();
    since = 100;
    for (int i = 0; i < 400; i++) begin
      u    = 1'($urandom_range(0, 1));
      flip = 2'b00;
      if (since >= 20 && $urandom_range(0, 49) == 0) begin
        flip  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        since = 0;
      end else begin
        since++;
      end
      send_bit(u, flip, "rnd");
    end
    for (int i = 0; i < DI - 1; i++) send_bit(1'b0, 2'b00, "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
